// File: rtl/cache_arbiter_if.sv
// rtl/cache_arbiter_if.sv - client and cache handshake bundle for cache_arbiter
interface cache_arbiter_if #(
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 8
);
   // CPU client port
   logic [ADDR_WIDTH-1:0] cpu_address;
   logic [DATA_WIDTH-1:0] cpu_data_write;
   logic                  cpu_read_req;
   logic                  cpu_write_req;
   logic [DATA_WIDTH-1:0] cpu_data_read;
   logic                  cpu_read_ack;
   logic                  cpu_write_ack;

   // WOPI client port
   logic [ADDR_WIDTH-1:0] wopi_address;
   logic [DATA_WIDTH-1:0] wopi_data_write;
   logic                  wopi_read_req;
   logic                  wopi_write_req;
   logic [DATA_WIDTH-1:0] wopi_data_read;
   logic                  wopi_read_ack;
   logic                  wopi_write_ack;

   // cache device port
   logic [ADDR_WIDTH-1:0] cache_address;
   logic [DATA_WIDTH-1:0] cache_data_write;
   logic                  cache_read_req;
   logic                  cache_write_req;
   logic [DATA_WIDTH-1:0] cache_data_read;
   logic                  cache_read_ack;
   logic                  cache_write_ack;

   logic                  busy;

   // arbiter side
   modport master (
      input  cpu_address, cpu_data_write, cpu_read_req, cpu_write_req,
      output cpu_data_read, cpu_read_ack, cpu_write_ack,
      input  wopi_address, wopi_data_write, wopi_read_req, wopi_write_req,
      output wopi_data_read, wopi_read_ack, wopi_write_ack,
      output cache_address, cache_data_write, cache_read_req, cache_write_req,
      input  cache_data_read, cache_read_ack, cache_write_ack,
      output busy
   );

   // clients plus cache side
   modport slave (
      output cpu_address, cpu_data_write, cpu_read_req, cpu_write_req,
      input  cpu_data_read, cpu_read_ack, cpu_write_ack,
      output wopi_address, wopi_data_write, wopi_read_req, wopi_write_req,
      input  wopi_data_read, wopi_read_ack, wopi_write_ack,
      input  cache_address, cache_data_write, cache_read_req, cache_write_req,
      output cache_data_read, cache_read_ack, cache_write_ack,
      input  busy
   );
endinterface

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - two-port CPU/WOPI arbiter in front of the SDRAM cache
module cache_arbiter #(
   parameter int ADDR_WIDTH     = 17,
   parameter int DATA_WIDTH     = 8,
   parameter int FIXED_PRIORITY = 0
) (
   input logic             sys_clk,
   input logic             reset,
   cache_arbiter_if.master bus
);

   localparam logic [2:0] ARB_IDLE       = 3'd0;
   localparam logic [2:0] ARB_READ       = 3'd1;
   localparam logic [2:0] ARB_WRITE      = 3'd2;
   localparam logic [2:0] ARB_WRITE_HOLD = 3'd3;
   localparam logic [2:0] ARB_RELEASE    = 3'd4;

   localparam logic PORT_CPU  = 1'b0;
   localparam logic PORT_WOPI = 1'b1;

   logic [2:0]            state;
   logic                  grant;
   logic                  last_grant;

   logic [ADDR_WIDTH-1:0] cache_address_reg;
   logic [DATA_WIDTH-1:0] cache_data_write_reg;
   logic                  cache_read_req_reg;
   logic                  cache_write_req_reg;

   logic [DATA_WIDTH-1:0] cpu_data_read_reg;
   logic [DATA_WIDTH-1:0] wopi_data_read_reg;
   logic                  cpu_read_ack_reg;
   logic                  cpu_write_ack_reg;
   logic                  wopi_read_ack_reg;
   logic                  wopi_write_ack_reg;

   logic                  cpu_pending;
   logic                  wopi_pending;
   logic                  pick;
   logic                  pick_read;
   logic [ADDR_WIDTH-1:0] pick_address;
   logic [DATA_WIDTH-1:0] pick_data;

   // choose the port to grant next and mux its request fields
   always_comb begin
      cpu_pending  = bus.cpu_read_req | bus.cpu_write_req;
      wopi_pending = bus.wopi_read_req | bus.wopi_write_req;
      if (cpu_pending && wopi_pending) begin
         // contention: CPU always in fixed mode, otherwise whoever did not go last
         pick = (FIXED_PRIORITY != 0) ? PORT_CPU : ~last_grant;
      end else begin
         pick = wopi_pending ? PORT_WOPI : PORT_CPU;
      end
      // a port asking for both read and write gets its read first
      pick_read    = (pick == PORT_WOPI) ? bus.wopi_read_req   : bus.cpu_read_req;
      pick_address = (pick == PORT_WOPI) ? bus.wopi_address    : bus.cpu_address;
      pick_data    = (pick == PORT_WOPI) ? bus.wopi_data_write : bus.cpu_data_write;
   end

   // arbitration state machine and all registered outputs
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state               <= ARB_IDLE;
         grant               <= PORT_CPU;
         last_grant          <= PORT_WOPI;
         cache_address_reg   <= '0;
         cache_data_write_reg<= '0;
         cache_read_req_reg  <= 1'b0;
         cache_write_req_reg <= 1'b0;
         cpu_data_read_reg   <= '0;
         wopi_data_read_reg  <= '0;
         cpu_read_ack_reg    <= 1'b0;
         cpu_write_ack_reg   <= 1'b0;
         wopi_read_ack_reg   <= 1'b0;
         wopi_write_ack_reg  <= 1'b0;
      end else begin
         // client acks are single-cycle pulses
         cpu_read_ack_reg   <= 1'b0;
         cpu_write_ack_reg  <= 1'b0;
         wopi_read_ack_reg  <= 1'b0;
         wopi_write_ack_reg <= 1'b0;

         case (state)
            ARB_IDLE: begin
               if (cpu_pending || wopi_pending) begin
                  grant             <= pick;
                  last_grant        <= pick;
                  cache_address_reg <= pick_address;
                  if (pick_read) begin
                     cache_read_req_reg <= 1'b1;
                     state              <= ARB_READ;
                  end else begin
                     cache_data_write_reg <= pick_data;
                     cache_write_req_reg  <= 1'b1;
                     state                <= ARB_WRITE;
                  end
               end
            end

            ARB_READ: begin
               if (bus.cache_read_ack) begin
                  cache_read_req_reg <= 1'b0;
                  if (grant == PORT_WOPI) begin
                     wopi_data_read_reg <= bus.cache_data_read;
                     wopi_read_ack_reg  <= 1'b1;
                  end else begin
                     cpu_data_read_reg <= bus.cache_data_read;
                     cpu_read_ack_reg  <= 1'b1;
                  end
                  state <= ARB_RELEASE;
               end
            end

            ARB_WRITE: begin
               // address and write byte stay put: the cache takes the byte a cycle after its ack
               if (bus.cache_write_ack) begin
                  cache_write_req_reg <= 1'b0;
                  // the client write ack is high for the whole hold cycle
                  if (grant == PORT_WOPI) begin
                     wopi_write_ack_reg <= 1'b1;
                  end else begin
                     cpu_write_ack_reg <= 1'b1;
                  end
                  state <= ARB_WRITE_HOLD;
               end
            end

            ARB_WRITE_HOLD: begin
               state <= ARB_RELEASE;
            end

            ARB_RELEASE: begin
               // gives the acked client a cycle to drop its request
               state <= ARB_IDLE;
            end

            default: begin
               state <= ARB_IDLE;
            end
         endcase
      end
   end

   assign bus.cache_address    = cache_address_reg;
   assign bus.cache_data_write = cache_data_write_reg;
   assign bus.cache_read_req   = cache_read_req_reg;
   assign bus.cache_write_req  = cache_write_req_reg;
   assign bus.cpu_data_read    = cpu_data_read_reg;
   assign bus.wopi_data_read   = wopi_data_read_reg;
   assign bus.cpu_read_ack     = cpu_read_ack_reg;
   assign bus.cpu_write_ack    = cpu_write_ack_reg;
   assign bus.wopi_read_ack    = wopi_read_ack_reg;
   assign bus.wopi_write_ack   = wopi_write_ack_reg;
   assign bus.busy             = (state != ARB_IDLE);

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - randomized self-checking bench for cache_arbiter (both priority modes)
module tb_cache_arbiter;
   localparam int AW   = 17;
   localparam int DW   = 8;
   localparam int NCYC = 2000;

   logic sys_clk = 1'b0;
   logic reset   = 1'b1;
   always #5 sys_clk = ~sys_clk;

   // stimulus per instance [inst][port], port 0 = CPU, 1 = WOPI; inst index = FIXED_PRIORITY
   logic [AW-1:0] c_addr [2][2];
   logic [DW-1:0] c_wd   [2][2];
   logic          c_rd   [2][2];
   logic          c_wr   [2][2];
   logic [DW-1:0] k_dr   [2];
   logic          k_rack [2];
   logic          k_wack [2];

   // observed outputs
   logic [1:0][DW-1:0] o_cdr, o_wdr, o_wd;
   logic [1:0][AW-1:0] o_addr;
   logic [1:0]         o_crack, o_cwack, o_wrack, o_wwack, o_rreq, o_wreq, o_busy;

   for (genvar g = 0; g < 2; g++) begin : g_inst
      cache_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();
      cache_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(g)) u_dut (
         .sys_clk (sys_clk),
         .reset   (reset),
         .bus     (ifc)
      );
      assign ifc.cpu_address     = c_addr[g][0];
      assign ifc.cpu_data_write  = c_wd[g][0];
      assign ifc.cpu_read_req    = c_rd[g][0];
      assign ifc.cpu_write_req   = c_wr[g][0];
      assign ifc.wopi_address    = c_addr[g][1];
      assign ifc.wopi_data_write = c_wd[g][1];
      assign ifc.wopi_read_req   = c_rd[g][1];
      assign ifc.wopi_write_req  = c_wr[g][1];
      assign ifc.cache_data_read = k_dr[g];
      assign ifc.cache_read_ack  = k_rack[g];
      assign ifc.cache_write_ack = k_wack[g];
      assign o_cdr[g]   = ifc.cpu_data_read;
      assign o_wdr[g]   = ifc.wopi_data_read;
      assign o_crack[g] = ifc.cpu_read_ack;
      assign o_cwack[g] = ifc.cpu_write_ack;
      assign o_wrack[g] = ifc.wopi_read_ack;
      assign o_wwack[g] = ifc.wopi_write_ack;
      assign o_addr[g]  = ifc.cache_address;
      assign o_wd[g]    = ifc.cache_data_write;
      assign o_rreq[g]  = ifc.cache_read_req;
      assign o_wreq[g]  = ifc.cache_write_req;
      assign o_busy[g]  = ifc.busy;
   end

   int vectors     = 0;
   int miscompares = 0;
   int n           = 0;

   // transaction-timeline reference model
   bit            m_act     [2];
   bit            m_wr      [2];
   int            m_port    [2];
   int            m_last    [2];
   int            m_end     [2];
   int            m_ack_cyc [2];
   int            m_ack_port[2];
   bit            m_ack_wr  [2];
   logic [AW-1:0] m_addr    [2];
   logic [DW-1:0] m_wd      [2];
   logic [DW-1:0] m_dr      [2][2];

   bit e_busy [2], e_rreq [2], e_wreq [2];
   bit e_rack [2][2], e_wack [2][2];

   // cache responder state
   int cnt [2];
   bit cwr [2];

   int rst_cyc      = -100;
   int quiet_until  = 0;
   bit rst_done     = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         if (miscompares <= 40)
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", tag, n, obs, exp);
      end
   endtask

   task automatic model_reset(input int i);
      m_act[i] = 0; m_wr[i] = 0; m_port[i] = 0; m_last[i] = 1;
      m_end[i] = 0; m_ack_cyc[i] = -1; m_ack_port[i] = 0; m_ack_wr[i] = 0;
      m_addr[i] = '0; m_wd[i] = '0; m_dr[i][0] = '0; m_dr[i][1] = '0;
   endtask

   // what happens at the rising edge that ends cycle cyc
   task automatic model_edge(input int i, input int cyc);
      bit pc, pw;
      int port;
      if (reset) begin
         model_reset(i);
      end else if (m_act[i]) begin
         if (m_wr[i] ? k_wack[i] : k_rack[i]) begin
            m_act[i]      = 0;
            m_ack_cyc[i]  = cyc + 1;
            m_ack_port[i] = m_port[i];
            m_ack_wr[i]   = m_wr[i];
            if (!m_wr[i]) begin
               m_dr[i][m_port[i]] = k_dr[i];
               m_end[i] = cyc + 2;
            end else begin
               m_end[i] = cyc + 3;
            end
         end
      end else if (cyc >= m_end[i]) begin
         pc = c_rd[i][0] | c_wr[i][0];
         pw = c_rd[i][1] | c_wr[i][1];
         if (pc || pw) begin
            if (pc && pw) port = (i == 1) ? 0 : (m_last[i] == 0 ? 1 : 0);
            else          port = pc ? 0 : 1;
            m_wr[i]   = !c_rd[i][port];
            m_addr[i] = c_addr[i][port];
            if (m_wr[i]) m_wd[i] = c_wd[i][port];
            m_port[i] = port;
            m_last[i] = port;
            m_act[i]  = 1;
         end
      end
   endtask

   task automatic compute_exp(input int i, input int cyc);
      e_busy[i] = m_act[i] || (cyc < m_end[i]);
      e_rreq[i] = m_act[i] && !m_wr[i];
      e_wreq[i] = m_act[i] && m_wr[i];
      for (int p = 0; p < 2; p++) begin
         e_rack[i][p] = (cyc == m_ack_cyc[i]) && !m_ack_wr[i] && (m_ack_port[i] == p);
         e_wack[i][p] = (cyc == m_ack_cyc[i]) &&  m_ack_wr[i] && (m_ack_port[i] == p);
      end
   endtask

   task automatic check_all(input int i);
      check($sformatf("fp%0d busy", i),             o_busy[i],  e_busy[i]);
      check($sformatf("fp%0d cache_read_req", i),   o_rreq[i],  e_rreq[i]);
      check($sformatf("fp%0d cache_write_req", i),  o_wreq[i],  e_wreq[i]);
      check($sformatf("fp%0d cache_address", i),    o_addr[i],  m_addr[i]);
      check($sformatf("fp%0d cache_data_write", i), o_wd[i],    m_wd[i]);
      check($sformatf("fp%0d cpu_data_read", i),    o_cdr[i],   m_dr[i][0]);
      check($sformatf("fp%0d wopi_data_read", i),   o_wdr[i],   m_dr[i][1]);
      check($sformatf("fp%0d cpu_read_ack", i),     o_crack[i], e_rack[i][0]);
      check($sformatf("fp%0d cpu_write_ack", i),    o_cwack[i], e_wack[i][0]);
      check($sformatf("fp%0d wopi_read_ack", i),    o_wrack[i], e_rack[i][1]);
      check($sformatf("fp%0d wopi_write_ack", i),   o_wwack[i], e_wack[i][1]);
   endtask

   task automatic new_request(input int i, input int p);
      int k;
      k = $urandom_range(0, 2);
      c_rd[i][p]   = (k != 1);
      c_wr[i][p]   = (k != 0);
      c_addr[i][p] = AW'($urandom);
      c_wd[i][p]   = DW'($urandom);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         for (int p = 0; p < 2; p++) begin
            c_addr[i][p] = '0; c_wd[i][p] = '0; c_rd[i][p] = 0; c_wr[i][p] = 0;
         end
         k_dr[i] = '0; k_rack[i] = 0; k_wack[i] = 0; cnt[i] = -1; cwr[i] = 0;
         model_reset(i);
      end
      @(posedge sys_clk);
      for (int i = 0; i < 2; i++) compute_exp(i, 0);

      for (n = 0; n < NCYC; n++) begin
         @(negedge sys_clk);
         for (int i = 0; i < 2; i++) check_all(i);

         // one reset in the middle of a cache read, with a late cache ack right after
         if (!rst_done && n >= 1000 && (e_rreq[0] || n == 1300)) begin
            rst_done    = 1;
            rst_cyc     = n;
            quiet_until = n + 12;
         end
         reset = (n < 3) || (n == rst_cyc);

         // clients retire acknowledged requests, then maybe issue new ones
         for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
               if (e_rack[i][p]) c_rd[i][p] = 0;
               if (e_wack[i][p]) c_wr[i][p] = 0;
               if (n == rst_cyc) begin
                  c_rd[i][p] = 0; c_wr[i][p] = 0;
               end
            end
            if (n == 4) begin
               c_rd[i][0] = 1; c_addr[i][0] = 17'h00123;
            end
            if (n == 20) begin
               c_wr[i][1] = 1; c_addr[i][1] = 17'h1FFFF; c_wd[i][1] = 8'h5A;
            end
            if (n == 35) begin
               c_rd[i][0] = 1; c_wr[i][0] = 1; c_addr[i][0] = 17'h0ABCD; c_wd[i][0] = 8'h3C;
            end
            if (n >= 60 && n >= quiet_until) begin
               for (int p = 0; p < 2; p++) begin
                  if (!c_rd[i][p] && !c_wr[i][p] &&
                      (((n >= 400 && n < 900) || n >= 1000) || $urandom_range(0, 3) == 0))
                     new_request(i, p);
               end
            end
         end

         // cache responder with random latency and occasional stray acks
         for (int i = 0; i < 2; i++) begin
            k_rack[i] = 0; k_wack[i] = 0; k_dr[i] = DW'($urandom);
            if (reset) begin
               cnt[i] = -1;
            end else begin
               if (cnt[i] < 0 && (e_rreq[i] || e_wreq[i])) begin
                  cnt[i] = (n < 60) ? 2 : $urandom_range(0, 3);
                  cwr[i] = e_wreq[i];
               end
               if (cnt[i] == 0) begin
                  if (cwr[i]) k_wack[i] = 1;
                  else begin
                     k_rack[i] = 1;
                     if (n < 20) k_dr[i] = 8'hA5;
                  end
                  cnt[i] = -1;
               end else if (cnt[i] > 0) begin
                  cnt[i]--;
               end else if (n == rst_cyc + 1) begin
                  k_rack[i] = 1;
               end else if (n >= 60 && !e_rreq[i] && !e_wreq[i] && $urandom_range(0, 7) == 0) begin
                  if ($urandom_range(0, 1) == 0) k_rack[i] = 1;
                  else                           k_wack[i] = 1;
               end
            end
         end

         for (int i = 0; i < 2; i++) begin
            model_edge(i, n);
            compute_exp(i, n + 1);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
